// File: rtl/prog_pri_arb.sv
// Programmable-priority arbiter: circular lowest-set-bit search from a pointer that is
// software-loaded (fixed mode) or auto-advanced past each accepted grant (round-robin).
module prog_pri_arb #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             mode,
  input  logic             ptr_ld,
  input  logic [IDX_W-1:0] ptr_val,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [WIDTH-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] ptr
);

  localparam int unsigned       CMP_W    = IDX_W + 1;
  localparam logic [CMP_W-1:0]  PTR_LIM  = CMP_W'(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  logic             accept;
  logic             en;
  logic [IDX_W-1:0] ld_val;
  logic [IDX_W-1:0] adv;
  logic [IDX_W-1:0] ptr_eff;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sel;
  logic [IDX_W-1:0] sel_idx;

  // Pointer selection: load beats round-robin advance beats hold.
  always_comb begin
    accept = gnt_valid & gnt_ready;
    en     = ~gnt_valid | gnt_ready;
    ld_val = ({1'b0, ptr_val} >= PTR_LIM) ? '0 : ptr_val;
    adv    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    if (ptr_ld) begin
      ptr_eff = ld_val;
    end else if (mode & accept) begin
      ptr_eff = adv;
    end else begin
      ptr_eff = ptr;
    end
  end

  // Circular search: lowest request at or above ptr_eff, else wrap to lowest request overall.
  always_comb begin
    hi = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hi[i] = req[i] & (IDX_W'(i) >= ptr_eff);
    end
    cand = (|hi) ? hi : req;
    sel  = cand & (~cand + WIDTH'(1));
    sel_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sel[i]) begin
        sel_idx = sel_idx | IDX_W'(i);
      end
    end
  end

  // Output stage holds its grant while stalled; pointer tracks ptr_eff every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_valid <= 1'b0;
      gnt       <= '0;
      gnt_idx   <= '0;
      ptr       <= '0;
    end else begin
      ptr <= ptr_eff;
      if (en) begin
        gnt_valid <= |req;
        gnt       <= sel;
        gnt_idx   <= sel_idx;
      end
    end
  end

endmodule
